// File: rtl/counter_timer_pkg.sv
// Shared types and default widths for the counter/timer controller slice.
package counter_timer_pkg;
   localparam int unsigned WIDTH_DEF      = 16;
   localparam int unsigned PRESCALE_W_DEF = 8;
   localparam int unsigned TICK_CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } ctr_state_e;
endpackage

// File: rtl/counter_timer_ctrl_if.sv
// Command/status bundle between a register front-end (master) and the timer (slave).
// tick_cnt exists only when COUNTER_TIMER_CTRL_TICK_CNT_EN is defined.
interface counter_timer_ctrl_if
   import counter_timer_pkg::*;
   #(parameter int unsigned WIDTH = WIDTH_DEF,
     parameter int unsigned PRESCALE_W = PRESCALE_W_DEF);
   logic                  start;
   logic                  stop;
   logic                  mode_periodic;
   logic [WIDTH-1:0]      period;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic                  tick;
   logic                  done;
`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
   logic [TICK_CNT_W-1:0] tick_cnt;

   modport master (output start, stop, mode_periodic, period, prescale,
                   input  count, busy, tick, done, tick_cnt);
   modport slave  (input  start, stop, mode_periodic, period, prescale,
                   output count, busy, tick, done, tick_cnt);
`else
   modport master (output start, stop, mode_periodic, period, prescale,
                   input  count, busy, tick, done);
   modport slave  (input  start, stop, mode_periodic, period, prescale,
                   output count, busy, tick, done);
`endif
endinterface

// File: rtl/counter_timer_core.sv
// Prescaler + up counter datapath; reports each step and the terminal (wrap) step.
module counter_timer_core
   import counter_timer_pkg::*;
   #(parameter int unsigned WIDTH = WIDTH_DEF,
     parameter int unsigned PRESCALE_W = PRESCALE_W_DEF)
   (input  logic                  clock0,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      period_q,
    input  logic [PRESCALE_W-1:0] prescale_q,
    output logic [WIDTH-1:0]      count,
    output logic                  step,
    output logic                  wrap);

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]      count_q, count_d;

   assign step  = enable && (presc_q == prescale_q);
   assign wrap  = step && (count_q == period_q);
   assign count = count_q;

   always_comb begin
      presc_d = presc_q;
      count_d = count_q;
      if (clear) begin
         presc_d = '0;
         count_d = '0;
      end else if (enable) begin
         if (step) begin
            presc_d = '0;
            count_d = wrap ? '0 : count_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         count_q <= '0;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/counter_timer_ctrl.sv
// Start/pause/resume/terminal-count sequencer around counter_timer_core.
// Optional tick counter output: COUNTER_TIMER_CTRL_TICK_CNT_EN.
module counter_timer_ctrl
   import counter_timer_pkg::*;
   #(parameter int unsigned WIDTH = WIDTH_DEF,
     parameter int unsigned PRESCALE_W = PRESCALE_W_DEF)
   (input logic clock0,
    input logic reset,
    counter_timer_ctrl_if.slave bus);

   ctr_state_e            state_q, state_d;
   logic [WIDTH-1:0]      period_q, period_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  mode_q, mode_d;
   logic                  tick_q, tick_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  core_en, core_clr, core_step, core_wrap, start_idle;
   logic [WIDTH-1:0]      core_count;

   // stop outranks start everywhere, so a start only counts without stop
   assign start_idle = (state_q == IDLE) && bus.start && !bus.stop;
   assign core_en    = (state_q == RUN) && !bus.stop;
   assign core_clr   = start_idle || ((state_q == PAUSE) && bus.stop);

   counter_timer_core #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) u_core (
      .clock0     (clock0),
      .reset      (reset),
      .enable     (core_en),
      .clear      (core_clr),
      .period_q   (period_q),
      .prescale_q (prescale_q),
      .count      (core_count),
      .step       (core_step),
      .wrap       (core_wrap));

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      mode_d     = mode_q;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: if (start_idle) begin
            period_d   = bus.period;
            prescale_d = bus.prescale;
            mode_d     = bus.mode_periodic;
            state_d    = RUN;
         end
         RUN: if (bus.stop) begin
            state_d = PAUSE;
         end else if (core_step && core_wrap) begin
            tick_d = 1'b1;
            if (!mode_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         PAUSE: if (bus.stop) state_d = IDLE;
                else if (bus.start) state_d = RUN;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         period_q   <= '0;
         prescale_q <= '0;
         mode_q     <= 1'b0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         mode_q     <= mode_d;
         tick_q     <= tick_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.count = core_count;
   assign bus.busy  = busy_q;
   assign bus.tick  = tick_q;
   assign bus.done  = done_q;

`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
   logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

   // counts in step with tick so both become visible in the same cycle
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (start_idle) tick_cnt_d = '0;
      else if (tick_d && (tick_cnt_q != '1)) tick_cnt_d = tick_cnt_q + 1'b1;
   end

   always_ff @(posedge clock0 or posedge reset) begin
      if (reset) tick_cnt_q <= '0;
      else       tick_cnt_q <= tick_cnt_d;
   end

   assign bus.tick_cnt = tick_cnt_q;
`endif
endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Self-checking bench for counter_timer_ctrl: vector table plus hand-written corner sequences.
module tb_counter_timer_ctrl;
   import counter_timer_pkg::*;

   logic clock0 = 1'b0;
   logic reset  = 1'b1;
   always #5 clock0 = ~clock0;

   counter_timer_ctrl_if bus ();
   counter_timer_ctrl dut (.clock0(clock0), .reset(reset), .bus(bus));

   typedef struct packed {logic [15:0] c; logic b; logic t; logic d;} obs_t;
   typedef struct {obs_t e; string name;} sb_t;
   typedef struct {int mode; int per; int pre; int st; int sp; int ec; int eb; int et; int ed;} vec_t;

   sb_t  sb_q[$];
   vec_t tbl[22];
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t observe();
      return {bus.count, bus.busy, bus.tick, bus.done};
   endfunction

   function automatic vec_t mk(int mode, int per, int pre, int st, int sp,
                               int ec, int eb, int et, int ed);
      return '{mode, per, pre, st, sp, ec, eb, et, ed};
   endfunction

   task automatic compare(string name, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got count=%0d busy=%b tick=%b done=%b, want count=%0d busy=%b tick=%b done=%b",
                  name, act.c, act.b, act.t, act.d, exp.c, exp.b, exp.t, exp.d);
      end
   endtask

   task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive commands, queue the expectation for the
   // state after the next rising edge, then check it on the following falling edge.
   task automatic cyc(int st, int sp, int ec, int eb, int et, int ed, string name);
      sb_t s;
      obs_t e;
      e.c = 16'(ec); e.b = 1'(eb); e.t = 1'(et); e.d = 1'(ed);
      bus.start = 1'(st);
      bus.stop  = 1'(sp);
      sb_q.push_back('{e: e, name: name});
      @(posedge clock0);
      @(negedge clock0);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      s = sb_q.pop_front();
      compare(s.name, observe(), s.e);
   endtask

   task automatic cfg(int mode, int per, int pre);
      bus.mode_periodic = 1'(mode);
      bus.period        = 16'(per);
      bus.prescale      = 8'(pre);
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0;
      cfg(0, 0, 0);

      // rows 1..8 change the inputs mid-run; only the values at start matter
      tbl[0]  = mk(1, 3, 0, 1, 0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 7, 5, 0, 0, 1, 1, 0, 0);
      tbl[2]  = mk(0, 7, 5, 0, 0, 2, 1, 0, 0);
      tbl[3]  = mk(0, 7, 5, 0, 0, 3, 1, 0, 0);
      tbl[4]  = mk(0, 7, 5, 0, 0, 0, 1, 1, 0);
      tbl[5]  = mk(0, 7, 5, 0, 0, 1, 1, 0, 0);
      tbl[6]  = mk(0, 7, 5, 0, 0, 2, 1, 0, 0);
      tbl[7]  = mk(0, 7, 5, 0, 0, 3, 1, 0, 0);
      tbl[8]  = mk(0, 7, 5, 0, 0, 0, 1, 1, 0);
      tbl[9]  = mk(0, 7, 5, 1, 1, 0, 1, 0, 0);
      tbl[10] = mk(0, 7, 5, 0, 0, 0, 1, 0, 0);
      tbl[11] = mk(0, 7, 5, 0, 1, 0, 0, 0, 0);
      tbl[12] = mk(0, 7, 5, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk(0, 2, 1, 1, 0, 0, 1, 0, 0);
      tbl[14] = mk(0, 2, 1, 0, 0, 0, 1, 0, 0);
      tbl[15] = mk(0, 2, 1, 0, 0, 1, 1, 0, 0);
      tbl[16] = mk(0, 2, 1, 0, 0, 1, 1, 0, 0);
      tbl[17] = mk(0, 2, 1, 0, 0, 2, 1, 0, 0);
      tbl[18] = mk(0, 2, 1, 0, 0, 2, 1, 0, 0);
      tbl[19] = mk(0, 2, 1, 0, 0, 0, 0, 1, 1);
      tbl[20] = mk(0, 2, 1, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 2, 1, 0, 0, 0, 0, 0, 0);

      #2 compare("reset_state", observe(), '0);
`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
      chk8("reset_tick_cnt", bus.tick_cnt, 8'd0);
`endif
      @(negedge clock0);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         cfg(tbl[i].mode, tbl[i].per, tbl[i].pre);
         cyc(tbl[i].st, tbl[i].sp, tbl[i].ec, tbl[i].eb, tbl[i].et, tbl[i].ed,
             $sformatf("vec%0d", i));
      end

      // pause at 5, hold, resume
      cfg(1, 10, 0);
      cyc(1, 0, 0, 1, 0, 0, "pause_start");
      for (int i = 1; i <= 5; i++) cyc(0, 0, i, 1, 0, 0, "pause_run");
      cyc(0, 1, 5, 1, 0, 0, "pause_enter");
      for (int i = 0; i < 7; i++) cyc(0, 0, 5, 1, 0, 0, "pause_hold");
      cyc(1, 0, 5, 1, 0, 0, "resume_edge");
      cyc(0, 0, 6, 1, 0, 0, "resume_next");
      cyc(0, 1, 6, 1, 0, 0, "resume_pause");
      cyc(0, 1, 0, 0, 0, 0, "resume_clear");

      // async reset while a tick is showing
      cfg(1, 1, 0);
      cyc(1, 0, 0, 1, 0, 0, "rst_start");
      cyc(0, 0, 1, 1, 0, 0, "rst_run");
      cyc(0, 0, 0, 1, 1, 0, "rst_tick");
      #2 reset = 1'b1;
      #1 compare("async_reset", observe(), '0);
`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
      chk8("async_reset_tick_cnt", bus.tick_cnt, 8'd0);
`endif
      @(negedge clock0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, "idle_after_reset");

      // period 0: tick every RUN cycle; tick_cnt saturates
      cfg(1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, "p0_start");
      for (int i = 1; i <= 300; i++) begin
         cyc(0, 0, 0, 1, 1, 0, "p0_tick");
`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
         chk8("tick_cnt", bus.tick_cnt, (i > 255) ? 8'd255 : 8'(i));
`endif
      end
      cyc(0, 1, 0, 1, 0, 0, "p0_pause");
      cyc(0, 1, 0, 0, 0, 0, "p0_clear");
      cyc(1, 0, 0, 1, 0, 0, "p0_restart");
`ifdef COUNTER_TIMER_CTRL_TICK_CNT_EN
      chk8("tick_cnt_clear_on_start", bus.tick_cnt, 8'd0);
`endif
      cyc(0, 1, 0, 1, 0, 0, "p0_pause2");
      cyc(0, 1, 0, 0, 0, 0, "p0_clear2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
